// File: rtl/calc_port_responder.sv
// Calculator request/response port responder: accepts cmd+operand1, then operand2,
// and returns a one-cycle response LATENCY cycles later. Optional macro: CALC_ERR_CNT_EN.
module calc_port_responder #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic             c_clk,
    input  logic             reset,
    input  logic [3:0]       req_cmd_in,
    input  logic [WIDTH-1:0] req_data_in,
    output logic [1:0]       out_resp,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef CALC_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OP2  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_cmd;
    logic [WIDTH-1:0]   r_op1;
    logic [3:0]         r_cnt;
    logic [WIDTH+1:0]   r_res;
    logic [1:0]         r_resp;
    logic [WIDTH-1:0]   r_data;
    logic               r_busy;
    logic               w_done;
    logic [WIDTH+1:0]   w_calc;
    logic [WIDTH+1:0]   w_out;
`ifdef CALC_ERR_CNT_EN
    logic [7:0]         r_err_cnt;
`endif

    // Packs {response code, result}; errors always carry a zero result.
    function automatic logic [WIDTH+1:0] calc(input logic [3:0] cmd,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (cmd)
            4'd1: begin
                if (sum[WIDTH]) calc = {RESP_ERR, {WIDTH{1'b0}}};
                else            calc = {RESP_OK, sum[WIDTH-1:0]};
            end
            4'd2: begin
                if (b > a) calc = {RESP_ERR, {WIDTH{1'b0}}};
                else       calc = {RESP_OK, a - b};
            end
            4'd5:    calc = {RESP_OK, a << b[4:0]};
            4'd6:    calc = {RESP_OK, a >> b[4:0]};
            default: calc = {RESP_ERR, {WIDTH{1'b0}}};
        endcase
    endfunction

    // Next-state decode and completion strobe.
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        w_calc       = calc(r_cmd, r_op1, req_data_in);
        case (r_state)
            S_IDLE: begin
                if (req_cmd_in != 4'd0) w_next_state = S_OP2;
                else                    w_next_state = S_IDLE;
            end
            S_OP2: begin
                if (LATENCY == 1) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (r_state == S_OP2) w_out = w_calc;
        else                  w_out = r_res;
    end

    // State register.
    always_ff @(posedge c_clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Operand capture, latency counter and registered response outputs.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_cmd  <= 4'd0;
            r_op1  <= {WIDTH{1'b0}};
            r_cnt  <= 4'd0;
            r_res  <= {(WIDTH+2){1'b0}};
            r_resp <= RESP_NONE;
            r_data <= {WIDTH{1'b0}};
            r_busy <= 1'b0;
        end else begin
            if (r_state == S_IDLE && req_cmd_in != 4'd0) begin
                r_cmd <= req_cmd_in;
                r_op1 <= req_data_in;
            end
            if (r_state == S_OP2) begin
                r_res <= w_calc;
                r_cnt <= LAT_M1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_done) begin
                r_resp <= w_out[WIDTH+1:WIDTH];
                r_data <= w_out[WIDTH-1:0];
            end else begin
                r_resp <= RESP_NONE;
                r_data <= {WIDTH{1'b0}};
            end
            r_busy <= (w_next_state != S_IDLE);
        end
    end

`ifdef CALC_ERR_CNT_EN
    // Saturating count of error responses.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_err_cnt <= 8'd0;
        end else if (w_done && w_out[WIDTH+1:WIDTH] == RESP_ERR && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
    assign err_cnt = r_err_cnt;
`endif

    assign out_resp = r_resp;
    assign out_data = r_data;
    assign busy     = r_busy;

endmodule
